mxv_row_feeder: RTL and testbench



---
 rtl/mxv_row_feeder.sv | 128 ++++++++++++
 tb/tb_mxv_row_feeder.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxv_row_feeder.sv
// Issuer side of the MxV row/accumulate interface: streams one row of chunks from the
// row memory into the 8-lane organizer and captures its accumulated dot-product result.
module mxv_row_feeder #(
  parameter int element_width   = 32,
  parameter int no_of_units     = 8,
  parameter int addr_width      = 10,
  parameter int chunk_cnt_width = 8,
  parameter int timeout_cycles  = 256
) (
  input  logic                                 clk,
  input  logic                                 main_reset,
  input  logic                                 go,
  input  logic [addr_width-1:0]                row_base_addr,
  input  logic [chunk_cnt_width-1:0]           no_of_chunks,
  output logic                                 mem_rd_en,
  output logic [addr_width-1:0]                mem_addr,
  input  logic [no_of_units*element_width-1:0] mem_rd_data,
  output logic [no_of_units*element_width-1:0] adder_row_input,
  output logic                                 row_valid,
  output logic                                 row_last,
  output logic                                 accumulate_start,
  input  logic [element_width-1:0]             adder_output,
  input  logic                                 final_adder_finish,
  output logic [element_width-1:0]             result,
  output logic                                 result_valid,
  output logic                                 busy,
  output logic                                 timeout_err
);

  localparam int wdog_width = $clog2(timeout_cycles + 1);

  localparam logic [addr_width-1:0]      addr_one  = addr_width'(1);
  localparam logic [chunk_cnt_width-1:0] cnt_one   = chunk_cnt_width'(1);
  localparam logic [wdog_width-1:0]      wdog_one  = wdog_width'(1);
  localparam logic [wdog_width-1:0]      wdog_last = wdog_width'(timeout_cycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WAIT_RESULT,
    DONE
  } state_t;

  state_t                     state, state_next;
  logic [chunk_cnt_width-1:0] n_lat;
  logic [chunk_cnt_width-1:0] chunk_idx;
  logic [wdog_width-1:0]      wdog;
  logic                       rd_pending;
  logic                       last_pending;
  logic                       last_read;
  logic                       wdog_expired;

  assign last_read    = (chunk_idx == n_lat - cnt_one);
  assign wdog_expired = (wdog == wdog_last);

  assign mem_rd_en    = (state == FETCH);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

  always_comb begin
    // NOTE: next state defaults to the current state so no path through the case infers a latch.
    state_next = state;
    unique case (state)
      IDLE:        if (go) state_next = (no_of_chunks == '0) ? DONE : FETCH;
      FETCH:       if (last_read) state_next = DRAIN;
      DRAIN:       state_next = WAIT_RESULT;
      WAIT_RESULT: if (final_adder_finish || wdog_expired) state_next = DONE;
      DONE:        state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (main_reset) begin
      state            <= IDLE;
      n_lat            <= '0;
      chunk_idx        <= '0;
      wdog             <= '0;
      rd_pending       <= 1'b0;
      last_pending     <= 1'b0;
      mem_addr         <= '0;
      adder_row_input  <= '0;
      row_valid        <= 1'b0;
      row_last         <= 1'b0;
      accumulate_start <= 1'b0;
      result           <= '0;
      timeout_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register here sample the pre-edge values,
      // which is what makes the read -> data -> chunk pipeline line up one stage per cycle.
      state        <= state_next;
      rd_pending   <= mem_rd_en;
      last_pending <= mem_rd_en && last_read;
      row_valid    <= rd_pending;
      row_last     <= last_pending;
      if (rd_pending) adder_row_input <= mem_rd_data;

      // Start level rises with the first chunk and drops as DONE is entered.
      if (rd_pending)               accumulate_start <= 1'b1;
      else if (state_next == DONE)  accumulate_start <= 1'b0;

      unique case (state)
        IDLE: begin
          if (go) begin
            mem_addr    <= row_base_addr;
            n_lat       <= no_of_chunks;
            chunk_idx   <= '0;
            timeout_err <= 1'b0;
            if (no_of_chunks == '0) result <= '0;
          end
        end
        FETCH: begin
          mem_addr  <= mem_addr + addr_one;
          chunk_idx <= chunk_idx + cnt_one;
        end
        DRAIN: wdog <= '0;
        WAIT_RESULT: begin
          wdog <= wdog + wdog_one;
          if (final_adder_finish) result      <= adder_output;
          else if (wdog_expired)  timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_row_feeder.sv
// Scoreboard bench for mxv_row_feeder: a registered row-memory model feeds the DUT, and a
// negedge monitor pops expected reads, chunks and results as the DUT produces them.
module tb_mxv_row_feeder;

  localparam int EW    = 32;
  localparam int NU    = 8;
  localparam int AW    = 10;
  localparam int CW    = 8;
  localparam int ROW_W = NU * EW;

  typedef struct packed {
    logic [ROW_W-1:0] data;
    logic             last;
  } chunk_t;

  logic             clk = 1'b0;
  logic             main_reset = 1'b1;
  logic             go = 1'b0;
  logic [AW-1:0]    row_base_addr = '0;
  logic [CW-1:0]    no_of_chunks = '0;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_addr;
  logic [ROW_W-1:0] mem_rd_data = '0;
  logic [ROW_W-1:0] adder_row_input;
  logic             row_valid;
  logic             row_last;
  logic             accumulate_start;
  logic [EW-1:0]    adder_output = '1;
  logic             final_adder_finish = 1'b0;
  logic [EW-1:0]    result;
  logic             result_valid;
  logic             busy;
  logic             timeout_err;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [AW-1:0] exp_addr[$];
  chunk_t        exp_chunk[$];
  logic [EW-1:0] exp_result[$];
  int            rd_cyc[$];
  int            val_cyc[$];
  int            last_cyc[$];
  int            rv_cyc[$];
  int            acc_rise[$];
  logic [EW-1:0] last_result = '0;

  mxv_row_feeder dut (
    .clk                (clk),
    .main_reset         (main_reset),
    .go                 (go),
    .row_base_addr      (row_base_addr),
    .no_of_chunks       (no_of_chunks),
    .mem_rd_en          (mem_rd_en),
    .mem_addr           (mem_addr),
    .mem_rd_data        (mem_rd_data),
    .adder_row_input    (adder_row_input),
    .row_valid          (row_valid),
    .row_last           (row_last),
    .accumulate_start   (accumulate_start),
    .adder_output       (adder_output),
    .final_adder_finish (final_adder_finish),
    .result             (result),
    .result_valid       (result_valid),
    .busy               (busy),
    .timeout_err        (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word at address a: lane j = (j << 24) + a - 0xF, so word 0x010+k has low value k+1.
  function automatic logic [ROW_W-1:0] mem_word(input logic [AW-1:0] a);
    logic [ROW_W-1:0] w;
    for (int j = 0; j < NU; j++) w[j*EW +: EW] = (32'(j) << 24) + 32'(a) - 32'h0000_000F;
    return w;
  endfunction

  // Registered memory: data is only meaningful the cycle after a read.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_word(mem_addr) : {NU{32'hDEAD_BEEF}};

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); val_cyc.delete(); last_cyc.delete(); rv_cyc.delete(); acc_rise.delete();
  endtask

  task automatic start_row(input logic [AW-1:0] base, input logic [CW-1:0] n, output int g);
    logic [AW-1:0] a;
    chunk_t        ch;
    for (int k = 0; k < int'(n); k++) begin
      a = base + AW'(k);
      exp_addr.push_back(a);
      ch.data = mem_word(a);
      ch.last = (k == int'(n) - 1);
      exp_chunk.push_back(ch);
    end
    clear_logs();
    @(posedge clk);
    #1;
    go = 1'b1; row_base_addr = base; no_of_chunks = n; g = cyc;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic pulse_finish(input int c, input logic [EW-1:0] v);
    wait_until(c);
    final_adder_finish = 1'b1; adder_output = v;
    exp_result.push_back(v);
    last_result = v;
    wait_until(c + 1);
    final_adder_finish = 1'b0; adder_output = '1;
  endtask

  task automatic monitor();
    logic          acc_prev;
    logic [AW-1:0] a;
    chunk_t        ch;
    logic [EW-1:0] r;
    acc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (accumulate_start && !acc_prev) acc_rise.push_back(cyc);
      acc_prev = accumulate_start;
      if (mem_rd_en) begin
        rd_cyc.push_back(cyc);
        n_vec++;
        if (exp_addr.size() == 0) begin
          n_bad++; $display("FAIL unexpected_read cyc=%0d addr=%h required=no read", cyc, mem_addr);
        end else begin
          a = exp_addr.pop_front();
          if (mem_addr !== a) begin
            n_bad++; $display("FAIL read_addr cyc=%0d got=%h required=%h", cyc, mem_addr, a);
          end
        end
      end
      if (row_valid) begin
        val_cyc.push_back(cyc);
        if (row_last) last_cyc.push_back(cyc);
        n_vec++;
        if (exp_chunk.size() == 0) begin
          n_bad++; $display("FAIL unexpected_chunk cyc=%0d required=no row_valid", cyc);
        end else begin
          ch = exp_chunk.pop_front();
          if (adder_row_input !== ch.data || row_last !== ch.last) begin
            n_bad++;
            $display("FAIL chunk cyc=%0d got=%h last=%b required=%h last=%b",
                     cyc, adder_row_input, row_last, ch.data, ch.last);
          end
        end
        n_vec++;
        if (accumulate_start !== 1'b1) begin
          n_bad++; $display("FAIL acc_with_valid cyc=%0d got=%b required=1", cyc, accumulate_start);
        end
      end
      if (result_valid) begin
        rv_cyc.push_back(cyc);
        n_vec++;
        if (exp_result.size() == 0) begin
          n_bad++; $display("FAIL unexpected_result cyc=%0d got=%h required=no result_valid", cyc, result);
        end else begin
          r = exp_result.pop_front();
          if (result !== r) begin
            n_bad++; $display("FAIL result cyc=%0d got=%h required=%h", cyc, result, r);
          end
        end
        n_vec++;
        if (accumulate_start !== 1'b0) begin
          n_bad++; $display("FAIL acc_in_done cyc=%0d got=%b required=0", cyc, accumulate_start);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({mem_rd_en, row_valid, row_last, accumulate_start, result_valid, busy, timeout_err} !== 7'b0
        || adder_row_input !== '0 || result !== '0 || mem_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_state ctl=%b data=%h result=%h addr=%h required=all zero",
               {mem_rd_en, row_valid, row_last, accumulate_start, result_valid, busy, timeout_err},
               adder_row_input, result, mem_addr);
    end
    main_reset = 1'b0;
  endtask

  task automatic test_basic_row();
    int g;
    start_row(10'h010, 8'd3, g);
    pulse_finish(g + 10, 32'h4120_0000);
    wait_until(g + 14);
    n_vec++;
    if (rd_cyc.size() != 3 || rd_cyc[0] != g + 1 || rd_cyc[2] != g + 3) begin
      n_bad++; $display("FAIL basic_read_cycles got=%p required=%0d..%0d", rd_cyc, g + 1, g + 3);
    end
    n_vec++;
    if (val_cyc.size() != 3 || val_cyc[0] != g + 3 || val_cyc[2] != g + 5) begin
      n_bad++; $display("FAIL basic_valid_cycles got=%p required=%0d..%0d", val_cyc, g + 3, g + 5);
    end
    n_vec++;
    if (last_cyc.size() != 1 || last_cyc[0] != g + 5) begin
      n_bad++; $display("FAIL basic_last got=%p required=%0d", last_cyc, g + 5);
    end
    n_vec++;
    if (acc_rise.size() != 1 || acc_rise[0] != g + 3) begin
      n_bad++; $display("FAIL basic_acc_rise got=%p required=%0d", acc_rise, g + 3);
    end
    n_vec++;
    if (rv_cyc.size() != 1 || rv_cyc[0] != g + 11) begin
      n_bad++; $display("FAIL basic_result_pulse got=%p required=%0d", rv_cyc, g + 11);
    end
  endtask

  task automatic test_zero_chunks();
    int g;
    exp_result.push_back('0);
    last_result = '0;
    start_row(10'h123, 8'd0, g);
    wait_until(g + 6);
    n_vec++;
    if (rd_cyc.size() != 0 || acc_rise.size() != 0 || rv_cyc.size() != 1 || rv_cyc[0] != g + 1) begin
      n_bad++;
      $display("FAIL zero_row reads=%0d acc_rises=%0d rv=%p required=0,0,[%0d]",
               rd_cyc.size(), acc_rise.size(), rv_cyc, g + 1);
    end
  endtask

  task automatic test_addr_wrap();
    int g;
    start_row(10'h3FE, 8'd4, g);
    // A finish flag during FETCH must not be taken as the result.
    wait_until(g + 2);
    final_adder_finish = 1'b1; adder_output = 32'hBAD0_BAD0;
    wait_until(g + 3);
    final_adder_finish = 1'b0; adder_output = '1;
    pulse_finish(g + 7, 32'h3F80_0000);
    wait_until(g + 11);
    n_vec++;
    if (rd_cyc.size() != 4 || rd_cyc[3] != g + 4 || rv_cyc.size() != 1 || rv_cyc[0] != g + 8) begin
      n_bad++; $display("FAIL wrap_timing reads=%p rv=%p required reads to %0d, rv %0d",
                        rd_cyc, rv_cyc, g + 4, g + 8);
    end
  endtask

  task automatic test_timeout();
    int g, l;
    start_row(10'h020, 8'd2, g);
    l = g + 4;
    exp_result.push_back(last_result);
    wait_until(l + 255);
    n_vec++;
    if (timeout_err !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL timeout_early err=%b rv=%b busy=%b required=0,0,1",
                        timeout_err, result_valid, busy);
    end
    wait_until(l + 256);
    n_vec++;
    if (timeout_err !== 1'b1 || result_valid !== 1'b1) begin
      n_bad++; $display("FAIL timeout_fire err=%b rv=%b required=1,1", timeout_err, result_valid);
    end
    wait_until(l + 260);
    n_vec++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL timeout_sticky err=%b busy=%b required=1,0", timeout_err, busy);
    end
  endtask

  task automatic test_finish_beats_timeout();
    int g, l;
    start_row(10'h040, 8'd1, g);
    n_vec++;
    if (timeout_err !== 1'b0) begin
      n_bad++; $display("FAIL go_clears_err got=%b required=0", timeout_err);
    end
    l = g + 3;
    pulse_finish(l + 255, 32'h4049_0FDB);
    wait_until(l + 258);
    n_vec++;
    if (timeout_err !== 1'b0 || rv_cyc.size() != 1 || rv_cyc[0] != l + 256) begin
      n_bad++; $display("FAIL coincide err=%b rv=%p required=0,[%0d]", timeout_err, rv_cyc, l + 256);
    end
  endtask

  task automatic test_reset_mid_row();
    int g;
    start_row(10'h100, 8'd8, g);
    wait_until(g + 3);
    main_reset = 1'b1;
    wait_until(g + 4);
    main_reset = 1'b0;
    n_vec++;
    if ({mem_rd_en, row_valid, row_last, accumulate_start, result_valid, busy, timeout_err} !== 7'b0
        || adder_row_input !== '0 || result !== '0 || mem_addr !== '0) begin
      n_bad++; $display("FAIL mid_reset_state ctl=%b addr=%h required=all zero",
                        {mem_rd_en, row_valid, row_last, accumulate_start, result_valid, busy, timeout_err},
                        mem_addr);
    end
    wait_until(g + 20);
    n_vec++;
    if (rd_cyc.size() != 3 || val_cyc.size() != 1) begin
      n_bad++; $display("FAIL mid_reset_abort reads=%0d valids=%0d required=3,1", rd_cyc.size(), val_cyc.size());
    end
    exp_addr.delete(); exp_chunk.delete();
    last_result = '0;
    start_row(10'h180, 8'd2, g);
    pulse_finish(g + 4, 32'hC0A0_0000);
    wait_until(g + 8);
    n_vec++;
    if (rd_cyc.size() != 2 || val_cyc.size() != 2 || rv_cyc.size() != 1 || rv_cyc[0] != g + 5) begin
      n_bad++; $display("FAIL post_reset_row reads=%0d valids=%0d rv=%p required=2,2,[%0d]",
                        rd_cyc.size(), val_cyc.size(), rv_cyc, g + 5);
    end
  endtask

  task automatic test_busy_ignore();
    int            g, d, g2;
    logic [AW-1:0] a;
    chunk_t        ch;
    start_row(10'h050, 8'd3, g);
    wait_until(g + 2);
    go = 1'b1; row_base_addr = 10'h200; no_of_chunks = 8'd5;
    wait_until(g + 3);
    go = 1'b0;
    pulse_finish(g + 7, 32'h4000_0000);
    d = g + 8;
    wait_until(d);
    go = 1'b1; row_base_addr = 10'h300; no_of_chunks = 8'd2;
    wait_until(d + 1);
    row_base_addr = 10'h320;
    for (int k = 0; k < 2; k++) begin
      a = 10'h320 + AW'(k);
      exp_addr.push_back(a);
      ch.data = mem_word(a);
      ch.last = (k == 1);
      exp_chunk.push_back(ch);
    end
    g2 = d + 1;
    wait_until(d + 2);
    go = 1'b0;
    pulse_finish(g2 + 4, 32'h4040_0000);
    wait_until(g2 + 8);
    n_vec++;
    if (rd_cyc.size() != 5 || rd_cyc[2] != g + 3 || rd_cyc[3] != d + 2) begin
      n_bad++; $display("FAIL busy_ignore_reads got=%p required 3 reads to %0d then from %0d",
                        rd_cyc, g + 3, d + 2);
    end
    n_vec++;
    if (rv_cyc.size() != 2 || rv_cyc[0] != d || rv_cyc[1] != g2 + 5) begin
      n_bad++; $display("FAIL busy_ignore_results got=%p required=[%0d,%0d]", rv_cyc, d, g2 + 5);
    end
  endtask

  task automatic test_max_count();
    int g;
    start_row(10'h000, 8'd255, g);
    pulse_finish(g + 257, 32'h437F_0000);
    wait_until(g + 261);
    n_vec++;
    if (rd_cyc.size() != 255 || val_cyc.size() != 255 || last_cyc.size() != 1 || last_cyc[0] != g + 257) begin
      n_bad++; $display("FAIL max_count reads=%0d valids=%0d last=%p required=255,255,[%0d]",
                        rd_cyc.size(), val_cyc.size(), last_cyc, g + 257);
    end
    n_vec++;
    if (rv_cyc.size() != 1 || rv_cyc[0] != g + 258) begin
      n_bad++; $display("FAIL max_count_result got=%p required=[%0d]", rv_cyc, g + 258);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic_row();
    test_zero_chunks();
    test_addr_wrap();
    test_timeout();
    test_finish_beats_timeout();
    test_reset_mid_row();
    test_busy_ignore();
    test_max_count();
    n_vec++;
    if (exp_addr.size() != 0 || exp_chunk.size() != 0 || exp_result.size() != 0) begin
      n_bad++; $display("FAIL leftover_expected addr=%0d chunk=%0d result=%0d required=0,0,0",
                        exp_addr.size(), exp_chunk.size(), exp_result.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
